// File: rtl/jk_excite_drv.sv
// Turns a stream of target Q vectors into J/K drive for an external bank of JK flops,
// then checks the bank's fed-back q against each target and counts mismatches.
module jk_excite_drv #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int DC_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           tgt_data,
    input  logic                       tgt_valid,
    output logic                       tgt_ready,
    input  logic [WIDTH-1:0]           q_fb,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           j,
    output logic [WIDTH-1:0]           k,
    output logic                       drv_valid,
    output logic                       mismatch,
    output logic [7:0]                 err_cnt,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic DC_BIT = (DC_MODE != 0);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic [WIDTH-1:0]   exp_reg;
    logic [WIDTH-1:0]   head;
    logic [WIDTH-1:0]   j_exc, k_exc;
    logic               push, pop, check, miss_now;

    assign tgt_ready  = (count_reg < CW'(DEPTH));
    assign push       = tgt_valid && tgt_ready;
    // The FIFO head is consumed on the edge that leaves IDLE or CHECK.
    assign pop        = (state_reg != DRIVE) && (count_reg != '0);
    assign check      = (state_reg == CHECK);
    assign miss_now   = check && (q_fb != exp_reg);
    assign head       = mem[rd_ptr_reg];
    assign fifo_count = count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_exc
            // Currently-set bits only need K to decide; clear bits only need J.
            assign j_exc[gi] = q_fb[gi] ? DC_BIT     : head[gi];
            assign k_exc[gi] = q_fb[gi] ? ~head[gi]  : DC_BIT;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pop) state_next = DRIVE;
            DRIVE:   state_next = CHECK;
            CHECK:   state_next = pop ? DRIVE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= tgt_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            exp_reg    <= '0;
            j          <= '0;
            k          <= '0;
            drv_valid  <= 1'b0;
            mismatch   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state_reg <= state_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (pop) exp_reg <= head;
            j         <= pop ? j_exc : '0;
            k         <= pop ? k_exc : '0;
            drv_valid <= pop;
            mismatch  <= miss_now;
            if (clr_err)
                err_cnt <= '0;
            else if (miss_now && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_jk_excite_drv.sv
// Directed bench for jk_excite_drv: two instances (x=0 and x=1 fill) each driving a
// behavioural JK flop bank, with hand-computed excitation and timing expectations.
module tb_jk_excite_drv;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    logic [3:0] td0 = 0, td1 = 0;
    logic       tv0 = 0, tv1 = 0, clr0 = 0, clr1 = 0;
    logic       tr0, tr1, dv0, dv1, mm0, mm1;
    logic [3:0] j0, k0, j1, k1, q_fb0, q_fb1;
    logic [7:0] ec0, ec1;
    logic [2:0] fc0, fc1;

    logic [3:0] bank0, bank1, load_val1 = 0;
    logic       fault = 0, load1 = 0;

    int n_checks = 0;
    int n_pass   = 0;

    jk_excite_drv #(.WIDTH(4), .DEPTH(4), .DC_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tgt_data(td0), .tgt_valid(tv0), .tgt_ready(tr0),
        .q_fb(q_fb0), .clr_err(clr0), .j(j0), .k(k0), .drv_valid(dv0),
        .mismatch(mm0), .err_cnt(ec0), .fifo_count(fc0));

    jk_excite_drv #(.WIDTH(4), .DEPTH(4), .DC_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tgt_data(td1), .tgt_valid(tv1), .tgt_ready(tr1),
        .q_fb(q_fb1), .clr_err(clr1), .j(j1), .k(k1), .drv_valid(dv1),
        .mismatch(mm1), .err_cnt(ec1), .fifo_count(fc1));

    // Behavioural JK banks; bank0 can have its bit 0 stuck low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bank0 <= 4'b0000;
        else        bank0 <= (j0 & ~bank0) | (~k0 & bank0);
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     bank1 <= 4'b0000;
        else if (load1) bank1 <= load_val1;
        else            bank1 <= (j1 & ~bank1) | (~k1 & bank1);
    end
    assign q_fb0 = fault ? (bank0 & 4'b1110) : bank0;
    assign q_fb1 = bank1;

    // Excitation table with x filled by 0 (bench instance dut0).
    function automatic logic [7:0] exc0(input logic [3:0] q, input logic [3:0] t);
        logic [3:0] ej, ek;
        for (int b = 0; b < 4; b++) begin
            case ({q[b], t[b]})
                2'b00: begin ej[b] = 1'b0; ek[b] = 1'b0; end
                2'b01: begin ej[b] = 1'b1; ek[b] = 1'b0; end
                2'b10: begin ej[b] = 1'b0; ek[b] = 1'b1; end
                default: begin ej[b] = 1'b0; ek[b] = 1'b0; end
            endcase
        end
        return {ej, ek};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // One isolated target: push, find the drive cycle, check j/k, then the check result.
    task automatic run_one(input bit sel, input logic [3:0] data, input logic [3:0] ej,
                           input logic [3:0] ek, input logic emm, input logic clr,
                           input string tag);
        int n;
        @(negedge clk);
        if (sel) begin tv1 = 1; td1 = data; end
        else     begin tv0 = 1; td0 = data; end
        @(negedge clk);
        tv0 = 0; tv1 = 0;
        n = 0;
        while (!(sel ? dv1 : dv0) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drv"}, 32'(sel ? dv1 : dv0), 1);
        chk({tag, "_j"}, 32'(sel ? j1 : j0), 32'(ej));
        chk({tag, "_k"}, 32'(sel ? k1 : k0), 32'(ek));
        @(negedge clk);
        clr0 = clr;
        @(negedge clk);
        clr0 = 0;
        chk({tag, "_mm"}, 32'(sel ? mm1 : mm0), 32'(emm));
        $display("txn %s: data=%b j=%b k=%b mismatch=%b", tag, data,
                 sel ? j1 : j0, sel ? k1 : k0, sel ? mm1 : mm0);
    endtask

    logic [3:0] tg [9] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h5};
    int acc [9];
    int drv_at [9];

    initial begin
        // 1: reset quiet state
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t1_jk", 32'({j0, k0}), 0);
            chk("t1_dv", 32'(dv0), 0);
            chk("t1_rdy", 32'(tr0), 1);
            chk("t1_err", 32'(ec0), 0);
        end

        // 2: x=0 fill, bank 0000 -> 1010 -> 0110
        run_one(0, 4'b1010, 4'b1010, 4'b0000, 0, 0, "t2a");
        chk("t2a_bank", 32'(q_fb0), 32'(4'b1010));
        run_one(0, 4'b0110, 4'b0100, 4'b1000, 0, 0, "t2b");
        chk("t2b_bank", 32'(q_fb0), 32'(4'b0110));

        // 3: x=1 fill, bank preset 1100, target 1010
        @(negedge clk); load1 = 1; load_val1 = 4'b1100;
        @(negedge clk); load1 = 0;
        run_one(1, 4'b1010, 4'b1110, 4'b0111, 0, 0, "t3");
        chk("t3_bank", 32'(q_fb1), 32'(4'b1010));

        // 4: nine back-to-back pushes fill the 4-deep FIFO
        fork
            begin
                int idx = 0, e = 0;
                bit seen_full = 0, rdy;
                while (idx < 9 && e < 40) begin
                    @(negedge clk);
                    tv0 = 1; td0 = tg[idx];
                    if (!tr0 && !seen_full) begin
                        seen_full = 1;
                        chk("t4_full_cnt", 32'(fc0), 4);
                        chk("t4_full_idx", idx, 7);
                    end
                    rdy = tr0;
                    @(posedge clk);
                    if (rdy) begin acc[idx] = e; idx++; end
                    e++;
                end
                @(negedge clk);
                tv0 = 0;
                chk("t4_all_pushed", idx, 9);
            end
            begin
                int w = 0;
                logic [7:0] ex;
                for (int n = 0; n < 9; n++) begin
                    int lim = w + 20;
                    do begin
                        @(negedge clk);
                        w++;
                    end while (!dv0 && w < lim);
                    drv_at[n] = w;
                    ex = exc0(q_fb0, tg[n]);
                    chk("t4_drv", 32'(dv0), 1);
                    chk("t4_jk", 32'({j0, k0}), 32'(ex));
                    if (n > 0) chk("t4_gap", drv_at[n] - drv_at[n-1], 2);
                    $display("txn t4[%0d]: tgt=%b j=%b k=%b", n, tg[n], j0, k0);
                end
            end
        join
        chk("t4_acc6", acc[6], 6);
        chk("t4_acc7", acc[7], 8);
        chk("t4_acc8", acc[8], 10);
        repeat (3) @(negedge clk);
        chk("t4_bank", 32'(q_fb0), 32'(4'h5));
        chk("t4_err", 32'(ec0), 0);

        // 5: bit 0 stuck low -> three mismatches, then clr_err beats a fourth
        do_reset();
        fault = 1;
        run_one(0, 4'b0001, 4'b0001, 4'b0000, 1, 0, "t5a");
        @(negedge clk);
        chk("t5_pulse_len", 32'(mm0), 0);
        run_one(0, 4'b0001, 4'b0001, 4'b0000, 1, 0, "t5b");
        run_one(0, 4'b0001, 4'b0001, 4'b0000, 1, 0, "t5c");
        chk("t5_err3", 32'(ec0), 3);
        run_one(0, 4'b0001, 4'b0001, 4'b0000, 1, 1, "t5d");
        chk("t5_err_clr", 32'(ec0), 0);
        fault = 0;

        // 6: reset asserted mid-DRIVE with three targets queued
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tv0 = 1; td0 = 4'(i + 1);
            @(posedge clk);
        end
        @(negedge clk);
        tv0 = 0;
        chk("t6_pre_dv", 32'(dv0), 1);
        chk("t6_pre_cnt", 32'(fc0), 3);
        rst_n = 0;
        #1;
        chk("t6_rst_jk", 32'({j0, k0}), 0);
        chk("t6_rst_dv", 32'(dv0), 0);
        chk("t6_rst_cnt", 32'(fc0), 0);
        @(negedge clk);
        rst_n = 1;
        begin
            logic any = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                any = any | mm0 | dv0;
            end
            chk("t6_quiet", 32'(any), 0);
            chk("t6_cnt", 32'(fc0), 0);
            $display("txn t6: reset mid-drive, post-release activity=%b", any);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
